sram_frame_arbiter: RTL
=======================

// Module: sram_frame_arbiter
// PURPOSE
//  Shares the single 1Mx16 async SRAM frame buffer between three requesters: VGA scan-out reader
//  (highest priority), D8M camera pixel writer, and NIOS CPU port. Sits between the D8M_SET
//  write/read FIFOs, the NIOS SRAM bridge and the SRAM pins.
//  Issues one 2-cycle SRAM access per grant, back-to-back. Peak rate is 25 Mword/s at CLOCK_50.
// PARAMETERS
//  ADDR_W       20  SRAM word address width
//  DATA_W       16  SRAM data width
//  VGA_MAX_RUN  8   max consecutive VGA grants while a lower requester waits (1..255)
//  STAT_W       32  width of statistics counters (only with SRAM_ARB_STATS_EN)
// PORTS
//  CLOCK_50     in   1       system clock, 50 MHz
//  RESET_N      in   1       asynchronous active-low reset
//  vga_req      in   1       VGA read request; hold with vga_addr until vga_ack
//  vga_addr     in   ADDR_W  VGA read address
//  vga_ack      out  1       1-cycle pulse: VGA request accepted
//  vga_rvalid   out  1       1-cycle pulse: vga_rdata valid
//  vga_rdata    out  DATA_W  VGA read data
//  cam_req      in   1       camera write request; hold with addr/data until cam_ack
//  cam_addr     in   ADDR_W  camera write address
//  cam_wdata    in   DATA_W  camera write data (both bytes written)
//  cam_ack      out  1       1-cycle pulse: camera write accepted
//  cpu_req      in   1       CPU request; hold with we/addr/wdata/be until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_be       in   2       byte enables {UB,LB}, active high
//  cpu_ack      out  1       1-cycle pulse: CPU request accepted
//  cpu_rvalid   out  1       1-cycle pulse: cpu_rdata valid (reads only)
//  cpu_rdata    out  DATA_W  CPU read data
//  SRAM_ADDR    out  ADDR_W  SRAM address
//  SRAM_DQ      inout DATA_W SRAM data bus
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out 1 each  SRAM strobes, active low
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; RR pointer=CAM; run counter=0; all acks/rvalids=0.
//    rdata=0; SRAM_ADDR=0; CE_N/OE_N/WE_N/LB_N/UB_N=1; SRAM_DQ tri-stated.
//  - FSM states: IDLE, ACC1 (setup), ACC2 (strobe/sample). Arbitration occurs in IDLE and ACC2.
//    Winner -> ACC1 next cycle; no request -> IDLE. ACC1 -> ACC2 always.
//  - Priority: VGA first, unless run counter == VGA_MAX_RUN and cam_req|cpu_req is set.
//    In that case VGA is skipped for one grant. CAM vs CPU alternates round-robin; the RR pointer
//    moves past the winner on each CAM/CPU grant.
//  - Run counter: +1 per VGA grant (saturates at VGA_MAX_RUN); cleared on any CAM/CPU grant.
//  - Request sampled in cycle N (IDLE or ACC2) -> ack pulses in N+1 (= ACC1).
//    Address, data, we and be are registered in N+1.
//    Requester may change its payload or drop req from N+2 on. A req dropped before ack is never
//    granted, with no side effects.
//  - ACC1: SRAM_ADDR driven, CE_N=0. Read: OE_N=0, LB_N/UB_N=0.
//    Write: DQ driven, LB_N/UB_N from byte enables (CAM: both 0).
//  - ACC2: write -> WE_N=0, DQ still driven. Read -> OE_N=0; DQ registered at the end of ACC2.
//  - Read latency: rvalid/rdata in cycle N+3 after the req-sample cycle N. rdata holds until the
//    next read for that port.
//  - Back-to-back: a new winner in ACC2 -> ACC1 immediately, so 2 cycles per access.
//    WE_N returns high for at least 1 cycle between writes. DQ is released in any cycle that is
//    not a write ACC1/ACC2, so there is no bus contention on read-after-write.
//  - CPU write with cpu_be=00: granted and acked; the SRAM cycle runs with LB_N=UB_N=1
//    (no data change).
//  - Addresses are used as-is; no wrap or range check (ADDR_W covers the whole SRAM).
// CONFIGURATION
//  - Macro SRAM_ARB_STATS_EN defined:
//    - Adds inputs stat_sel[1:0] (0=VGA, 1=CAM, 2=CPU, 3=starvation skips) and stat_clr.
//    - Adds output stat_count[STAT_W-1:0] (combinational mux of 4 saturating grant counters).
//    - stat_clr zeroes all four counters synchronously; clear wins over a same-cycle increment.
//    - Counters reset to 0.
//  - Macro not defined: ports and counters are absent; arbitration is identical.
// STRUCTURE
//  - Package sram_arb_pkg: ADDR_W/DATA_W defaults; enum req_id_t {REQ_NONE, REQ_VGA, REQ_CAM,
//    REQ_CPU}; enum arb_state_t {IDLE, ACC1, ACC2}; stat_sel encodings.
//  - Sub-module sram_arb_pick: combinational winner selection from reqs, RR pointer and
//    run-counter-at-limit. Outputs req_id_t.
//  - Top holds the FSM, RR pointer, run counter, payload registers, SRAM pin registers and
//    optional stats.
// TESTING
//  1. vga_req only, addr 0x00010; SRAM model returns 0xBEEF.
//     -> vga_ack at N+1, vga_rvalid with 0xBEEF at N+3; WE_N stays 1.
//  2. cam_req and cpu_req (write) held together for 4 grants
//     -> grant order CAM, CPU, CAM, CPU; SRAM sees 4 writes, 2 cycles apart.
//  3. vga_req held, cam_req held, VGA_MAX_RUN=8 -> 8 VGA acks, 1 CAM ack, then 8 VGA acks.
//  4. CPU write 0x1234 to 0x00ABC with be=01, then CPU read of the same address
//     -> model shows low byte 0x34 only; cpu_rdata low byte 0x34. No DQ contention
//     (checker: DQ driven only in write ACC1/ACC2).
//  5. RESET_N asserted in the middle of ACC2 of a write
//     -> all strobes 1 and DQ high-Z immediately; after release FSM=IDLE and no stale ack.
//  6. SRAM_ARB_STATS_EN: run scenario 3 for 17 grants; stat_sel=0 -> 16, 1 -> 1, 3 -> 1;
//     stat_clr -> 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and defaults for the SRAM frame-buffer arbiter.
//   SRAM_ADDR_W / SRAM_DATA_W : default SRAM geometry (1M x 16)
//   req_id_t                  : requester identity (also used as round-robin pointer)
//   arb_state_t               : access FSM states
//   STAT_SEL_*                : stat_sel encodings (used when SRAM_ARB_STATS_EN is defined)
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VGA,
    REQ_CAM,
    REQ_CPU
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2
  } arb_state_t;

  localparam logic [1:0] STAT_SEL_VGA  = 2'd0;
  localparam logic [1:0] STAT_SEL_CAM  = 2'd1;
  localparam logic [1:0] STAT_SEL_CPU  = 2'd2;
  localparam logic [1:0] STAT_SEL_SKIP = 2'd3;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner selection.
//   vga_req, cam_req, cpu_req : pending requests
//   rr_ptr                    : REQ_CAM or REQ_CPU, the side favoured on a CAM/CPU tie
//   run_at_limit              : VGA has used its maximum consecutive grants
//   winner                    : granted requester, REQ_NONE when nothing is pending
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic    vga_req,
  input  logic    cam_req,
  input  logic    cpu_req,
  input  req_id_t rr_ptr,
  input  logic    run_at_limit,
  output req_id_t winner
);

  logic vga_blocked;

  // VGA yields exactly one grant once its run hits the limit and someone else waits.
  assign vga_blocked = run_at_limit & (cam_req | cpu_req);

  always_comb begin
    winner = REQ_NONE;
    if (vga_req && !vga_blocked) begin
      winner = REQ_VGA;
    end else if (cam_req && cpu_req) begin
      winner = (rr_ptr == REQ_CPU) ? REQ_CPU : REQ_CAM;
    end else if (cam_req) begin
      winner = REQ_CAM;
    end else if (cpu_req) begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: shares one async 1Mx16 SRAM between VGA reader (priority),
// camera writer and CPU port. Each grant runs a 2-cycle access (ACC1 setup,
// ACC2 strobe/sample); a new grant in ACC2 chains straight into the next ACC1.
//   CLOCK_50, RESET_N            : clock, async active-low reset
//   vga_req/addr -> ack/rvalid/rdata          : VGA read port
//   cam_req/addr/wdata -> ack                 : camera write port
//   cpu_req/we/addr/wdata/be -> ack/rvalid/rdata : CPU port
//   SRAM_*                       : SRAM pins (all registered)
// Optional feature macro SRAM_ARB_STATS_EN adds stat_sel/stat_clr/stat_count
// and four saturating grant counters (VGA, CAM, CPU, starvation skips).
module sram_frame_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned DATA_W      = SRAM_DATA_W,
  parameter int unsigned VGA_MAX_RUN = 8,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
`ifdef SRAM_ARB_STATS_EN
  input  logic [1:0]        stat_sel,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_count,
`endif
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  logic [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  arb_state_t        state_q, state_d;
  req_id_t           rr_ptr_q;
  req_id_t           owner_q;
  req_id_t           winner;
  logic [7:0]        run_cnt_q;
  logic              run_at_limit;
  logic              arb_slot;
  logic              grant;
  logic              acc_we_q;
  logic              dq_oe_q;
  logic [DATA_W-1:0] dq_out_q;

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              g_we;
  logic              g_lb_n;
  logic              g_ub_n;

  assign run_at_limit = (run_cnt_q == 8'(VGA_MAX_RUN));
  assign arb_slot     = (state_q == IDLE) || (state_q == ACC2);
  assign grant        = arb_slot && (winner != REQ_NONE);

  sram_arb_pick u_pick (
    .vga_req      (vga_req),
    .cam_req      (cam_req),
    .cpu_req      (cpu_req),
    .rr_ptr       (rr_ptr_q),
    .run_at_limit (run_at_limit),
    .winner       (winner)
  );

  // Data bus is driven only during write ACC1/ACC2.
  assign SRAM_DQ = dq_oe_q ? dq_out_q : 'z;

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC2: state_d = grant ? ACC1 : IDLE;
      ACC1:       state_d = ACC2;
      default:    state_d = IDLE;
    endcase
  end

  // Payload of the current winner.
  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_we   = 1'b0;
    g_lb_n = 1'b0;
    g_ub_n = 1'b0;
    case (winner)
      REQ_VGA: begin
        g_addr = vga_addr;
      end
      REQ_CAM: begin
        g_addr = cam_addr;
        g_data = cam_wdata;
        g_we   = 1'b1;
      end
      REQ_CPU: begin
        g_addr = cpu_addr;
        g_data = cpu_wdata;
        g_we   = cpu_we;
        g_lb_n = cpu_we & ~cpu_be[0];
        g_ub_n = cpu_we & ~cpu_be[1];
      end
      default: ;
    endcase
  end

  // ---------------- Arbitration state ----------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_ptr_q  <= REQ_CAM;
      run_cnt_q <= '0;
    end else if (grant) begin
      case (winner)
        REQ_VGA: if (!run_at_limit) run_cnt_q <= run_cnt_q + 8'd1;
        REQ_CAM: begin
          run_cnt_q <= '0;
          rr_ptr_q  <= REQ_CPU;
        end
        REQ_CPU: begin
          run_cnt_q <= '0;
          rr_ptr_q  <= REQ_CAM;
        end
        default: ;
      endcase
    end
  end

  // ---------------- Handshakes and SRAM pins ----------------
  // Pins for ACC1 are loaded on the grant edge, so an ACC2 grant needs no idle gap.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q    <= REQ_NONE;
      acc_we_q   <= 1'b0;
      vga_ack    <= 1'b0;
      cam_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rdata  <= '0;
      cpu_rdata  <= '0;
      SRAM_ADDR  <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      vga_ack    <= 1'b0;
      cam_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      SRAM_WE_N  <= 1'b1;

      if (state_q == ACC1 && acc_we_q) begin
        SRAM_WE_N <= 1'b0;
      end

      if (state_q == ACC2 && !acc_we_q) begin
        if (owner_q == REQ_VGA) begin
          vga_rdata  <= SRAM_DQ;
          vga_rvalid <= 1'b1;
        end else if (owner_q == REQ_CPU) begin
          cpu_rdata  <= SRAM_DQ;
          cpu_rvalid <= 1'b1;
        end
      end

      if (grant) begin
        owner_q   <= winner;
        acc_we_q  <= g_we;
        vga_ack   <= (winner == REQ_VGA);
        cam_ack   <= (winner == REQ_CAM);
        cpu_ack   <= (winner == REQ_CPU);
        SRAM_ADDR <= g_addr;
        SRAM_CE_N <= 1'b0;
        SRAM_OE_N <= g_we;
        SRAM_LB_N <= g_lb_n;
        SRAM_UB_N <= g_ub_n;
        dq_oe_q   <= g_we;
        dq_out_q  <= g_data;
      end else if (arb_slot) begin
        owner_q   <= REQ_NONE;
        acc_we_q  <= 1'b0;
        SRAM_CE_N <= 1'b1;
        SRAM_OE_N <= 1'b1;
        SRAM_LB_N <= 1'b1;
        SRAM_UB_N <= 1'b1;
        dq_oe_q   <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // ---------------- Optional statistics ----------------
  logic [STAT_W-1:0] stat_q [4];
  logic [3:0]        stat_inc;

  always_comb begin
    stat_inc = '0;
    stat_inc[STAT_SEL_VGA]  = grant && (winner == REQ_VGA);
    stat_inc[STAT_SEL_CAM]  = grant && (winner == REQ_CAM);
    stat_inc[STAT_SEL_CPU]  = grant && (winner == REQ_CPU);
    stat_inc[STAT_SEL_SKIP] = arb_slot && vga_req && run_at_limit && (cam_req || cpu_req);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < 4; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (stat_inc[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  assign stat_count = stat_q[stat_sel];
`endif

endmodule
